intpol2_job_scheduler: RTL

Job sequencer that sits in front of the intpol2_D4 core. It accepts interpolation job descriptors (bypass, mode, iX, iX2, ilen) from a host-side valid/ready interface and buffers them in a small descriptor queue. For each job it drives the core's 128-bit config_reg, issues a single-cycle start, and monitors status_reg busy/done. It reports per-job completion or timeout back to the host.

---
 rtl/intpol2_job_scheduler.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/intpol2_job_scheduler.sv
// rtl/intpol2_job_scheduler.sv - descriptor queue and start/done sequencer for the intpol2_D4 core
// Optional job statistics counters are enabled by defining INTPOL2_SCHED_STATS_EN.
module intpol2_job_scheduler #(
  parameter int CONFIG_WIDTH   = 32,
  parameter int DATAPATH_WIDTH = 12,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic                            job_bypass,
  input  logic                            job_mode,
  input  logic [DATAPATH_WIDTH-1:0]       job_ix,
  input  logic [DATAPATH_WIDTH-1:0]       job_ix2,
  input  logic [CONFIG_WIDTH-1:0]         job_len,
  input  logic [TIMEOUT_WIDTH-1:0]        to_limit,
  input  logic                            abort,
  output logic [4*CONFIG_WIDTH-1:0]       config_reg,
  output logic                            start,
  input  logic [7:0]                      status_reg,
  output logic                            job_done,
  output logic                            job_err,
  output logic [$clog2(QUEUE_DEPTH):0]    q_level,
  output logic                            idle
`ifdef INTPOL2_SCHED_STATS_EN
  ,
  output logic [15:0]                     jobs_ok,
  output logic [15:0]                     jobs_err
`endif
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int DW = 2 + 2 * DATAPATH_WIDTH + CONFIG_WIDTH;
  localparam logic [AW:0]              FULL_LEVEL = (AW + 1)'(QUEUE_DEPTH);
  localparam logic [AW:0]              LVL_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0]            PTR_ONE    = AW'(1);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE     = TIMEOUT_WIDTH'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [DW-1:0]              q_mem [QUEUE_DEPTH];
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [2:0]                 state;
  logic [TIMEOUT_WIDTH-1:0]   to_cnt;
  logic [DW-1:0]              head;
  logic [4*CONFIG_WIDTH-1:0]  head_cfg;
  logic                       push;
  logic                       pop;
  logic                       core_done;
  logic                       core_busy;
  logic                       to_hit;
  logic                       unused_status;

  assign job_ready = (q_level != FULL_LEVEL);
  assign push      = job_valid && job_ready && !abort;
  assign pop       = (state == S_IDLE) && (q_level != '0) && !abort;

  assign core_done     = status_reg[0];
  assign core_busy     = status_reg[1];
  assign unused_status = ^status_reg[7:2];

  assign to_hit = (to_limit != '0) && (to_cnt == to_limit - TO_ONE);

  // Descriptor layout in the queue: {len, ix2, ix, mode, bypass}.
  assign head     = q_mem[rd_ptr];
  assign head_cfg = {head[DW-1 -: CONFIG_WIDTH],
                     {(CONFIG_WIDTH - DATAPATH_WIDTH){1'b0}}, head[2+DATAPATH_WIDTH +: DATAPATH_WIDTH],
                     {(CONFIG_WIDTH - DATAPATH_WIDTH){1'b0}}, head[2 +: DATAPATH_WIDTH],
                     {(CONFIG_WIDTH - 2){1'b0}}, head[1:0]};

  assign start    = (state == S_START);
  assign job_done = (state == S_DONE);
  assign job_err  = (state == S_ERR);
  assign idle     = (state == S_IDLE) && (q_level == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr] <= {job_len, job_ix2, job_ix, job_mode, job_bypass};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_level    <= '0;
      state      <= S_IDLE;
      to_cnt     <= '0;
      config_reg <= '0;
    end else if (abort) begin
      // Flush only; config_reg keeps the last loaded job for debug visibility.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_level <= '0;
      state   <= S_IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   q_level <= q_level + LVL_ONE;
        2'b01:   q_level <= q_level - LVL_ONE;
        default: q_level <= q_level;
      endcase

      // config_reg is captured on entry to LOAD so it is settled a full cycle before start.
      case (state)
        S_IDLE: begin
          if (q_level != '0) begin
            config_reg <= head_cfg;
            state      <= S_LOAD;
          end
        end
        S_LOAD:  state <= S_START;
        S_START: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          to_cnt <= to_cnt + TO_ONE;
          if (core_done)      state <= S_DONE;
          else if (to_hit)    state <= S_ERR;
          else if (core_busy) state <= S_RUN;
        end
        S_RUN: begin
          to_cnt <= to_cnt + TO_ONE;
          if (core_done)      state <= S_DONE;
          else if (to_hit)    state <= S_ERR;
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef INTPOL2_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      jobs_ok  <= '0;
      jobs_err <= '0;
    end else begin
      if (job_done && jobs_ok != 16'hFFFF)  jobs_ok  <= jobs_ok + 16'd1;
      if (job_err && jobs_err != 16'hFFFF)  jobs_err <= jobs_err + 16'd1;
    end
  end
`endif

endmodule
